pool_scheduler: RTL and testbench
=================================

POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 Parameter MAP_W, default 24: feature-map width in pixels; SHALL be a multiple of POOL_K and ≤255.
REQ-002 Parameter MAP_H, default 24: feature-map height in pixels; SHALL be a multiple of POOL_K and ≤255.
REQ-003 Parameter POOL_K, default 2: pooling window size and stride.
REQ-004 Parameter LAT, default 3: pooling datapath latency in cycles, ≥1.
REQ-005 aclk  in  1: the single clock; all logic SHALL be on its rising edge.
REQ-006 areset  in  1: reset, synchronous and active-high.
REQ-007 iStart  in  1: frame start request, sampled only in IDLE.
REQ-008 iStall  in  1: downstream hold; suppresses window issue.
REQ-009 oBusy  out  1: high from frame acceptance through the oDone cycle.
REQ-010 oWinStart  out  1: one-cycle pulse per window issued to the pooling datapath.
REQ-011 oRow  out  8: top-left row of the issued window; valid with oWinStart.
REQ-012 oCol  out  8: top-left column of the issued window; valid with oWinStart.
REQ-013 oOutValid  out  1: oWinStart delayed exactly LAT cycles; marks the datapath result.
REQ-014 oDone  out  1: one-cycle pulse after the last result of the frame.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE with iStart=1 at edge N SHALL enter RUN, with oBusy=1 from cycle N+1.
REQ-018 In RUN, if iStall=0 at an edge, the next cycle SHALL have oWinStart=1 with the current (oRow, oCol); the column then advances by POOL_K.
REQ-019 In RUN, if iStall=1 at an edge, the next cycle SHALL have oWinStart=0, and the row/column counters SHALL hold.
REQ-020 First window SHALL be (0,0) and issued in cycle N+1 when not stalled.
REQ-021 Column wrap: after issuing column MAP_W-POOL_K, column SHALL return to 0 and row SHALL advance by POOL_K.
REQ-022 After issuing window (MAP_H-POOL_K, MAP_W-POOL_K), the FSM SHALL enter DRAIN; exactly (MAP_W/POOL_K)*(MAP_H/POOL_K) pulses are issued per frame.
REQ-023 oOutValid SHALL come from a LAT-deep shift line of oWinStart that shifts every cycle, including stalled cycles.
REQ-024 DRAIN SHALL end when the shift line is empty and the last oOutValid has been output; the next cycle SHALL be DONE with oDone=1.
REQ-025 DONE SHALL last one cycle and return to IDLE; oBusy SHALL be 0 from the cycle after oDone.
REQ-026 iStart while not IDLE SHALL be ignored and not queued.
REQ-027 iStart=1 in the DONE cycle SHALL be ignored; a new frame needs iStart in IDLE.
REQ-028 iStall SHALL have no effect in IDLE, DRAIN or DONE.
REQ-029 oRow/oCol SHALL hold their last issued value whenever oWinStart=0.

Reset
REQ-030 areset=1 at an edge SHALL force IDLE, clear counters and the shift line, and drive oBusy, oWinStart, oOutValid and oDone to 0 and oRow, oCol to 0 in the next cycle.
REQ-031 Reset mid-frame SHALL abort the frame with no oDone and no further oOutValid; areset SHALL take priority over iStart on the same edge.

Verification (MAP_W=MAP_H=4, POOL_K=2, LAT=3 unless noted)
REQ-032 iStart at edge 0, iStall=0 -> oWinStart cycles 1-4 at (0,0),(0,2),(2,0),(2,2); oOutValid cycles 4-7; oDone cycle 8; oBusy 1 in cycles 1-8.
REQ-033 Same frame with iStall=1 at edges 2-3 -> windows in cycles 1,2,5,6; oOutValid 4,5,8,9; oDone 10.
REQ-034 iStart re-pulsed at edges 3 and 8 -> both ignored; exactly 4 windows, single oDone at cycle 8, then IDLE.
REQ-035 areset at edge 3 mid-frame -> all outputs 0 from cycle 4; no oOutValid after cycle 3; no oDone; a fresh iStart at edge 6 gives (0,0) in cycle 7.
REQ-036 Default parameters (24x24, K=2, LAT=3), no stall -> 144 oWinStart pulses, the last at (22,22); oDone 4 cycles after the last oWinStart.

Source files
------------

// File: rtl/pool_scheduler.sv
// pool_scheduler
// Walks a MAP_H x MAP_W feature map in POOL_K x POOL_K windows (stride
// POOL_K) and issues one window start per unstalled cycle to a pooling
// datapath of latency LAT. It tracks the datapath results through a
// LAT-deep shift line and pulses oDone once the last result has left it.
//
// Ports
//   aclk      : clock, rising edge
//   areset    : synchronous active-high reset
//   iStart    : frame start request, sampled only in IDLE
//   iStall    : downstream hold, suppresses window issue while running
//   oBusy     : high from frame acceptance through the oDone cycle
//   oWinStart : one-cycle pulse per issued window
//   oRow/oCol : top-left corner of the issued window, held between pulses
//   oOutValid : oWinStart delayed by exactly LAT cycles
//   oDone     : one-cycle pulse after the last result of the frame
module pool_scheduler #(
    parameter int MAP_W  = 24,
    parameter int MAP_H  = 24,
    parameter int POOL_K = 2,
    parameter int LAT    = 3
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       iStart,
    input  logic       iStall,
    output logic       oBusy,
    output logic       oWinStart,
    output logic [7:0] oRow,
    output logic [7:0] oCol,
    output logic       oOutValid,
    output logic       oDone
);

    localparam logic [7:0] LAST_COL = 8'(MAP_W - POOL_K);
    localparam logic [7:0] LAST_ROW = 8'(MAP_H - POOL_K);
    localparam logic [7:0] STEP     = 8'(POOL_K);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic [7:0]       orow_q, orow_d;
    logic [7:0]       ocol_q, ocol_d;
    logic             win_q, win_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LAT-1:0]   pipe_q, pipe_d;
    logic             issue;
    logic             pending;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        win_d   = 1'b0;
        issue   = 1'b0;

        // Shift line advances every cycle, stalled or not.
        pipe_d[0] = win_q;
        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // Results still in flight, excluding the one on oOutValid right now.
        pending = win_q;
        for (int unsigned i = 0; i + 1 < LAT; i++) begin
            pending = pending | pipe_q[i];
        end

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = RUN;
                    // The accepting edge already issues window (0,0).
                    issue   = !iStall;
                end
            end
            RUN: begin
                issue = !iStall;
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            win_d  = 1'b1;
            orow_d = row_q;
            ocol_d = col_q;
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    // Counters return to the origin ready for the next frame.
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    row_d = row_q + STEP;
                end
            end else begin
                col_d = col_q + STEP;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            win_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pipe_q  <= pipe_d;
        end
    end

    assign oBusy     = busy_q;
    assign oWinStart = win_q;
    assign oRow      = orow_q;
    assign oCol      = ocol_q;
    assign oOutValid = pipe_q[LAT-1];
    assign oDone     = done_q;

endmodule

// File: tb/tb_pool_scheduler.sv
// Bench for pool_scheduler: a 4x4 instance driven from a vector table and a
// default 24x24 instance checked against a window-queue reference model.
module tb_pool_scheduler;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Small instance (4x4, K=2, LAT=3)
    logic       s_rst, s_start, s_stall;
    logic       s_busy, s_win, s_ov, s_done;
    logic [7:0] s_row, s_col;

    // Default instance (24x24, K=2, LAT=3)
    logic       b_rst, b_start, b_stall;
    logic       b_busy, b_win, b_ov, b_done;
    logic [7:0] b_row, b_col;

    pool_scheduler #(.MAP_W(4), .MAP_H(4), .POOL_K(2), .LAT(3)) dut_s (
        .aclk(aclk), .areset(s_rst), .iStart(s_start), .iStall(s_stall),
        .oBusy(s_busy), .oWinStart(s_win), .oRow(s_row), .oCol(s_col),
        .oOutValid(s_ov), .oDone(s_done)
    );

    pool_scheduler dut_b (
        .aclk(aclk), .areset(b_rst), .iStart(b_start), .iStall(b_stall),
        .oBusy(b_busy), .oWinStart(b_win), .oRow(b_row), .oCol(b_col),
        .oOutValid(b_ov), .oDone(b_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int idx,
                         input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got busy/win/row/col/ov/done=%h required %h",
                     name, idx, act, exp);
        end
    endtask

    // ---------------- reference model for the default instance -----------
    localparam int BW = 24, BH = 24, BK = 2, BLAT = 3;
    int  wq[$];            // windows still to issue, encoded row*256+col
    bit  whist[int];       // cycle -> a window was issued in that cycle
    bit  m_active   = 1'b0;
    int  m_done_cyc = -1;
    int  m_rst_cyc  = 0;
    int  cyc        = 0;
    logic       m_busy, m_win, m_ov, m_done;
    logic [7:0] m_row = '0, m_col = '0;

    task automatic model_edge(input bit st, input bit sl, input bit rs);
        int nc;
        int w;
        nc     = cyc + 1;
        m_win  = 1'b0;
        m_done = 1'b0;
        if (rs) begin
            m_active   = 1'b0;
            wq.delete();
            m_done_cyc = -1;
            m_rst_cyc  = nc;
            m_row      = '0;
            m_col      = '0;
        end else begin
            if (!m_active && st) begin
                m_active = 1'b1;
                for (int r = 0; r < BH; r += BK)
                    for (int c = 0; c < BW; c += BK)
                        wq.push_back(r * 256 + c);
            end
            if (m_active && wq.size() > 0 && !sl) begin
                w     = wq.pop_front();
                m_win = 1'b1;
                m_row = 8'(w / 256);
                m_col = 8'(w % 256);
                if (wq.size() == 0) m_done_cyc = nc + BLAT + 1;
            end
            if (m_active && cyc == m_done_cyc) m_active = 1'b0;
            m_done = (nc == m_done_cyc);
        end
        m_busy    = m_active;
        whist[nc] = m_win;
        m_ov      = !rs && (nc - BLAT >= m_rst_cyc) && whist.exists(nc - BLAT)
                    && whist[nc - BLAT];
        cyc       = nc;
    endtask

    // One clock: drive both instances, step the model, check the big one.
    task automatic tick(input bit sst, input bit ssl, input bit srs,
                        input bit bst, input bit bsl, input bit brs);
        @(negedge aclk);
        s_start = sst; s_stall = ssl; s_rst = srs;
        b_start = bst; b_stall = bsl; b_rst = brs;
        model_edge(bst, bsl, brs);
        @(posedge aclk);
        #1;
        check("model", cyc, {b_busy, b_win, b_row, b_col, b_ov, b_done},
              {m_busy, m_win, m_row, m_col, m_ov, m_done});
    endtask

    // ---------------- vector table for the small instance ----------------
    typedef struct {
        bit          st, sl, rs;
        logic [19:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit st, input bit sl, input bit rs,
                       input bit busy, input bit win, input int row, input int col,
                       input bit ov, input bit done);
        vec_t v;
        v.st = st; v.sl = sl; v.rs = rs;
        v.exp = {busy, win, 8'(row), 8'(col), ov, done};
        vq.push_back(v);
    endtask

    int win_cnt, last_r, last_c, last_cyc, done_cyc;
    bit seen_done;

    initial begin
        s_rst = 1'b1; s_start = 1'b0; s_stall = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0;

        // st sl rs | busy win row col ov done  (expected in the following cycle)
        add(0,0,1, 0,0,0,0,0,0);                 // reset state
        // plain frame, iStart re-pulsed mid-frame and in the DONE cycle
        add(1,0,0, 1,1,0,0,0,0);
        add(0,0,0, 1,1,0,2,0,0);
        add(0,0,0, 1,1,2,0,0,0);
        add(1,0,0, 1,1,2,2,1,0);
        add(0,0,0, 1,0,2,2,1,0);
        add(0,1,0, 1,0,2,2,1,0);                 // stall in DRAIN has no effect
        add(0,0,0, 1,0,2,2,1,0);
        add(0,0,0, 1,0,2,2,0,1);
        add(1,0,0, 0,0,2,2,0,0);                 // iStart in DONE ignored
        add(0,0,0, 0,0,2,2,0,0);
        // frame stalled on two edges
        add(1,0,0, 1,1,0,0,0,0);
        add(0,0,0, 1,1,0,2,0,0);
        add(0,1,0, 1,0,0,2,0,0);
        add(0,1,0, 1,0,0,2,1,0);
        add(0,0,0, 1,1,2,0,1,0);
        add(0,0,0, 1,1,2,2,0,0);
        add(0,0,0, 1,0,2,2,0,0);
        add(0,0,0, 1,0,2,2,1,0);
        add(0,0,0, 1,0,2,2,1,0);
        add(0,0,0, 1,0,2,2,0,1);
        add(0,0,0, 0,0,2,2,0,0);
        // reset mid-frame (with iStart on the same edge), then a fresh frame
        add(1,0,0, 1,1,0,0,0,0);
        add(0,0,0, 1,1,0,2,0,0);
        add(0,0,0, 1,1,2,0,0,0);
        add(1,0,1, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0,0);
        add(1,0,0, 1,1,0,0,0,0);
        add(0,0,0, 1,1,0,2,0,0);
        add(0,1,0, 1,0,0,2,0,0);
        add(0,0,0, 1,1,2,0,1,0);
        add(0,0,0, 1,1,2,2,1,0);
        add(0,0,0, 1,0,2,2,0,0);
        add(0,0,0, 1,0,2,2,1,0);
        add(0,0,0, 1,0,2,2,1,0);
        add(0,0,0, 1,0,2,2,0,1);
        add(0,0,0, 0,0,2,2,0,0);

        foreach (vq[i]) begin
            tick(vq[i].st, vq[i].sl, vq[i].rs, 1'b0, 1'b0, (i == 0));
            check("vec", i, {s_busy, s_win, s_row, s_col, s_ov, s_done}, vq[i].exp);
        end

        // Default-size frame without stall: count, last window, done gap.
        win_cnt = 0; last_r = -1; last_c = -1; last_cyc = 0; done_cyc = 0;
        seen_done = 1'b0;
        tick(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 400 && !seen_done; k++) begin
            if (b_win) begin
                win_cnt++; last_r = b_row; last_c = b_col; last_cyc = cyc;
            end
            if (b_done) begin
                seen_done = 1'b1; done_cyc = cyc;
            end else begin
                tick(0, 0, 0, 0, 0, 0);
            end
        end
        check("done_seen", 0, 20'(seen_done), 20'd1);
        check("win_count", 0, 20'(win_cnt), 20'd144);
        check("last_win", 0, 20'(last_r * 256 + last_c), 20'(22 * 256 + 22));
        check("done_gap", 0, 20'(done_cyc - last_cyc), 20'd4);

        // Randomised traffic on the default instance.
        for (int k = 0; k < 4000; k++) begin
            tick(0, 0, 0,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 599) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
